voice_allocator: RTL and testbench

//  Polyphony controller for the 4-voice synth datapath. Accepts serialized note on/off events

---
 rtl/voice_allocator.sv | 236 +++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: 4-voice polyphony controller with LRU reuse.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all are busy.
module voice_allocator #(
  parameter int NOTE_W     = 7,
  parameter int STEP_W     = 16,
  parameter int GAP_CYCLES = 384
) (
  input  logic              iCLK_18_4,
  input  logic              iRST_N,
  input  logic              iNote_Valid,
  output logic              oNote_Ready,
  input  logic              iNote_On,
  input  logic [NOTE_W-1:0] iNote_Code,
  input  logic [STEP_W-1:0] iNote_Step,
  input  logic              iAll_Off,
  output logic [3:0]        oKey_On,
  output logic [STEP_W-1:0] oStep0,
  output logic [STEP_W-1:0] oStep1,
  output logic [STEP_W-1:0] oStep2,
  output logic [STEP_W-1:0] oStep3,
  output logic              oDrop
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY,
    S_GAP
  } state_t;

  typedef enum logic [2:0] {
    A_NONE,
    A_OFF,
    A_RETRIG,
    A_NEW,
    A_STEAL,
    A_DROP
  } act_t;

  state_t             state_q;
  act_t               act_q;
  act_t               act_d;
  logic [1:0]         sel_q;
  logic [1:0]         sel_d;

  logic               ev_on_q;
  logic [NOTE_W-1:0]  ev_code_q;
  logic [STEP_W-1:0]  ev_step_q;

  logic [3:0]         busy_q;
  logic [3:0]         key_q;
  logic [NOTE_W-1:0]  code_q [4];
  logic [STEP_W-1:0]  step_q [4];
  logic [1:0]         rank_q [4];
  logic [1:0]         rank_t [4];
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               drop_q;

  logic               match_ok;
  logic [1:0]         match_v;
  logic               free_ok;
  logic [1:0]         free_v;
  logic [1:0]         victim_v;

  assign oKey_On     = key_q;
  assign oStep0      = step_q[0];
  assign oStep1      = step_q[1];
  assign oStep2      = step_q[2];
  assign oStep3      = step_q[3];
  assign oNote_Ready = ready_q;
  assign oDrop       = drop_q;

  // Voice search: lowest matching busy voice, lowest free voice, oldest voice.
  always_comb begin
    match_ok = 1'b0;
    match_v  = 2'd0;
    free_ok  = 1'b0;
    free_v   = 2'd0;
    victim_v = 2'd0;
    for (int v = 3; v >= 0; v--) begin
      if (busy_q[v] && (code_q[v] == ev_code_q)) begin
        match_ok = 1'b1;
        match_v  = v[1:0];
      end
      if (!busy_q[v]) begin
        free_ok = 1'b1;
        free_v  = v[1:0];
      end
      if (rank_q[v] == 2'd3) begin
        victim_v = v[1:0];
      end
    end
  end

  // Decide what the latched event does to the voice bank.
  always_comb begin
    act_d = A_NONE;
    sel_d = 2'd0;
    unique case (1'b1)
      (!ev_on_q): begin
        act_d = match_ok ? A_OFF : A_NONE;
        sel_d = match_v;
      end
      (ev_on_q && match_ok): begin
        act_d = A_RETRIG;
        sel_d = match_v;
      end
      (ev_on_q && !match_ok && free_ok): begin
        act_d = A_NEW;
        sel_d = free_v;
      end
      default: begin
`ifdef VOICE_STEAL_EN
        act_d = A_STEAL;
        sel_d = victim_v;
`else
        act_d = A_DROP;
        sel_d = 2'd0;
`endif
      end
    endcase
  end

  // LRU ranks after touching the selected voice.
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      rank_t[u] = rank_q[u];
      if (u[1:0] == sel_q) begin
        rank_t[u] = 2'd0;
      end else if (rank_q[u] < rank_q[sel_q]) begin
        rank_t[u] = rank_q[u] + 2'd1;
      end
    end
  end

  // Event FSM, voice bank and registered outputs.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      act_q     <= A_NONE;
      sel_q     <= 2'd0;
      ev_on_q   <= 1'b0;
      ev_code_q <= '0;
      ev_step_q <= '0;
      busy_q    <= 4'b0000;
      key_q     <= 4'b0000;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      drop_q    <= 1'b0;
      for (int v = 0; v < 4; v++) begin
        code_q[v] <= '0;
        step_q[v] <= '0;
        rank_q[v] <= 2'(v);
      end
    end else begin
      drop_q <= 1'b0;
      if (iAll_Off) begin
        key_q   <= 4'b0000;
        busy_q  <= 4'b0000;
        cnt_q   <= '0;
        state_q <= S_IDLE;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (iNote_Valid) begin
              ev_on_q   <= iNote_On;
              ev_code_q <= iNote_Code;
              ev_step_q <= iNote_Step;
              ready_q   <= 1'b0;
              state_q   <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            act_q   <= act_d;
            sel_q   <= sel_d;
            state_q <= S_APPLY;
          end
          S_APPLY: begin
            unique case (act_q)
              A_OFF: begin
                key_q[sel_q]  <= 1'b0;
                busy_q[sel_q] <= 1'b0;
                ready_q       <= 1'b1;
                state_q       <= S_IDLE;
              end
              A_RETRIG, A_STEAL: begin
                key_q[sel_q]  <= 1'b0;
                step_q[sel_q] <= ev_step_q;
                code_q[sel_q] <= ev_code_q;
                rank_q        <= rank_t;
                cnt_q         <= CNT_W'(GAP_CYCLES - 1);
                state_q       <= S_GAP;
              end
              A_NEW: begin
                key_q[sel_q]  <= 1'b1;
                busy_q[sel_q] <= 1'b1;
                step_q[sel_q] <= ev_step_q;
                code_q[sel_q] <= ev_code_q;
                rank_q        <= rank_t;
                ready_q       <= 1'b1;
                state_q       <= S_IDLE;
              end
              A_DROP: begin
                drop_q  <= 1'b1;
                ready_q <= 1'b1;
                state_q <= S_IDLE;
              end
              default: begin
                ready_q <= 1'b1;
                state_q <= S_IDLE;
              end
            endcase
          end
          S_GAP: begin
            if (cnt_q == '0) begin
              key_q[sel_q] <= 1'b1;
              ready_q      <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed tests for the 4-voice allocator.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_voice_allocator;

  localparam int GAP = 384;

  logic        iCLK_18_4 = 1'b0;
  logic        iRST_N    = 1'b0;
  logic        iNote_Valid = 1'b0;
  logic        oNote_Ready;
  logic        iNote_On = 1'b0;
  logic [6:0]  iNote_Code = '0;
  logic [15:0] iNote_Step = '0;
  logic        iAll_Off = 1'b0;
  logic [3:0]  oKey_On;
  logic [15:0] oStep0, oStep1, oStep2, oStep3;
  logic        oDrop;

  int errors = 0;
  int checks = 0;

  always #27 iCLK_18_4 = ~iCLK_18_4;

  voice_allocator dut (
    .iCLK_18_4   (iCLK_18_4),
    .iRST_N      (iRST_N),
    .iNote_Valid (iNote_Valid),
    .oNote_Ready (oNote_Ready),
    .iNote_On    (iNote_On),
    .iNote_Code  (iNote_Code),
    .iNote_Step  (iNote_Step),
    .iAll_Off    (iAll_Off),
    .oKey_On     (oKey_On),
    .oStep0      (oStep0),
    .oStep1      (oStep1),
    .oStep2      (oStep2),
    .oStep3      (oStep3),
    .oDrop       (oDrop)
  );

  task automatic do_reset();
    iRST_N      = 1'b0;
    iNote_Valid = 1'b0;
    iAll_Off    = 1'b0;
    repeat (2) @(negedge iCLK_18_4);
    iRST_N = 1'b1;
    @(negedge iCLK_18_4);
  endtask

  // Offer one event; returns on the falling edge just after acceptance.
  task automatic send(input logic on, input logic [6:0] code,
                      input logic [15:0] step);
    int n;
    n = 0;
    while (oNote_Ready !== 1'b1 && n < 2000) begin
      @(negedge iCLK_18_4);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b required=1", oNote_Ready);
    end
    iNote_Valid = 1'b1;
    iNote_On    = on;
    iNote_Code  = code;
    iNote_Step  = step;
    @(posedge iCLK_18_4);
    @(negedge iCLK_18_4);
    iNote_Valid = 1'b0;
  endtask

  // Plain event: returns on the falling edge after the APPLY update.
  task automatic play(input logic on, input logic [6:0] code,
                      input logic [15:0] step);
    send(on, code, step);
    repeat (2) @(negedge iCLK_18_4);
  endtask

  task automatic fill4();
    play(1'b1, 7'd60, 16'h0010);
    play(1'b1, 7'd62, 16'h0020);
    play(1'b1, 7'd64, 16'h0030);
    play(1'b1, 7'd65, 16'h0040);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0000) begin
      errors++;
      $display("FAIL rst_key got=%b required=0000", oKey_On);
    end
    checks++;
    if ({oStep0, oStep1, oStep2, oStep3} !== 64'h0) begin
      errors++;
      $display("FAIL rst_step got=%h required=0",
               {oStep0, oStep1, oStep2, oStep3});
    end
    checks++;
    if (oNote_Ready !== 1'b1 || oDrop !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl ready=%b drop=%b required=1,0",
               oNote_Ready, oDrop);
    end
    iRST_N = 1'b1;
    @(negedge iCLK_18_4);
  endtask

  task automatic test_note_on();
    do_reset();
    send(1'b1, 7'd60, 16'h0100);
    checks++;
    if (oNote_Ready !== 1'b0) begin
      errors++;
      $display("FAIL on_busy ready=%b required=0", oNote_Ready);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0000) begin
      errors++;
      $display("FAIL on_early key=%b required=0000", oKey_On);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0001 || oStep0 !== 16'h0100) begin
      errors++;
      $display("FAIL on_apply key=%b step0=%h required=0001,0100",
               oKey_On, oStep0);
    end
    checks++;
    if (oNote_Ready !== 1'b1) begin
      errors++;
      $display("FAIL on_ready ready=%b required=1", oNote_Ready);
    end
  endtask

  task automatic test_reuse();
    do_reset();
    fill4();
    checks++;
    if (oKey_On !== 4'b1111 || oStep3 !== 16'h0040) begin
      errors++;
      $display("FAIL fill key=%b step3=%h required=1111,0040",
               oKey_On, oStep3);
    end
    play(1'b0, 7'd62, 16'h0000);
    checks++;
    if (oKey_On !== 4'b1101 || oStep1 !== 16'h0020) begin
      errors++;
      $display("FAIL off62 key=%b step1=%h required=1101,0020",
               oKey_On, oStep1);
    end
    play(1'b1, 7'd67, 16'h0200);
    checks++;
    if (oKey_On !== 4'b1111 || oStep1 !== 16'h0200 ||
        oStep2 !== 16'h0030) begin
      errors++;
      $display("FAIL reuse key=%b s1=%h s2=%h required=1111,0200,0030",
               oKey_On, oStep1, oStep2);
    end
  endtask

  task automatic test_retrigger();
    int low;
    int bad;
    do_reset();
    play(1'b1, 7'd60, 16'h0100);
    send(1'b1, 7'd60, 16'h0180);
    @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0001) begin
      errors++;
      $display("FAIL retrig_early key=%b required=0001", oKey_On);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0000 || oStep0 !== 16'h0180) begin
      errors++;
      $display("FAIL retrig_apply key=%b step0=%h required=0000,0180",
               oKey_On, oStep0);
    end
    low = 0;
    bad = 0;
    while (oKey_On[0] === 1'b0 && low < 1000) begin
      low++;
      if (oNote_Ready !== 1'b0) bad++;
      @(negedge iCLK_18_4);
    end
    checks++;
    if (low != GAP) begin
      errors++;
      $display("FAIL retrig_gap low=%0d required=%0d", low, GAP);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL retrig_ready_in_gap count=%0d required=0", bad);
    end
    checks++;
    if (oNote_Ready !== 1'b1 || oKey_On !== 4'b0001) begin
      errors++;
      $display("FAIL retrig_end ready=%b key=%b required=1,0001",
               oNote_Ready, oKey_On);
    end
  endtask

  task automatic test_all_busy();
`ifdef VOICE_STEAL_EN
    int low;
    int drops;
`endif
    do_reset();
    fill4();
    send(1'b1, 7'd70, 16'h0700);
`ifdef VOICE_STEAL_EN
    @(negedge iCLK_18_4);
    @(negedge iCLK_18_4);
    low = 0;
    drops = 0;
    while (oKey_On[0] === 1'b0 && low < 1000) begin
      low++;
      if (oDrop !== 1'b0) drops++;
      @(negedge iCLK_18_4);
    end
    checks++;
    if (low != GAP || oStep0 !== 16'h0700) begin
      errors++;
      $display("FAIL steal low=%0d step0=%h required=%0d,0700",
               low, oStep0, GAP);
    end
    checks++;
    if (drops != 0 || oKey_On !== 4'b1111) begin
      errors++;
      $display("FAIL steal_end drops=%0d key=%b required=0,1111",
               drops, oKey_On);
    end
    send(1'b1, 7'd72, 16'h0720);
    repeat (2) @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b1101 || oStep1 !== 16'h0720) begin
      errors++;
      $display("FAIL steal2 key=%b step1=%h required=1101,0720",
               oKey_On, oStep1);
    end
`else
    @(negedge iCLK_18_4);
    checks++;
    if (oDrop !== 1'b0) begin
      errors++;
      $display("FAIL drop_early drop=%b required=0", oDrop);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oDrop !== 1'b1 || oNote_Ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse drop=%b ready=%b required=1,1",
               oDrop, oNote_Ready);
    end
    checks++;
    if (oKey_On !== 4'b1111 || oStep0 !== 16'h0010) begin
      errors++;
      $display("FAIL drop_outs key=%b step0=%h required=1111,0010",
               oKey_On, oStep0);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oDrop !== 1'b0) begin
      errors++;
      $display("FAIL drop_width drop=%b required=0", oDrop);
    end
`endif
  endtask

  task automatic test_all_off();
    do_reset();
    play(1'b1, 7'd60, 16'h0100);
    send(1'b1, 7'd60, 16'h0180);
    repeat (12) @(negedge iCLK_18_4);
    iAll_Off    = 1'b1;
    iNote_Valid = 1'b1;
    iNote_On    = 1'b1;
    iNote_Code  = 7'd64;
    iNote_Step  = 16'h0400;
    @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0000 || oNote_Ready !== 1'b1 || oDrop !== 1'b0) begin
      errors++;
      $display("FAIL alloff key=%b ready=%b drop=%b required=0000,1,0",
               oKey_On, oNote_Ready, oDrop);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oNote_Ready !== 1'b1) begin
      errors++;
      $display("FAIL alloff_idle_offer ready=%b required=1", oNote_Ready);
    end
    iAll_Off    = 1'b0;
    iNote_Valid = 1'b0;
    repeat (GAP + 16) @(negedge iCLK_18_4);
    checks++;
    if (oKey_On !== 4'b0000 || oNote_Ready !== 1'b1 ||
        oStep0 !== 16'h0180) begin
      errors++;
      $display("FAIL alloff_hold key=%b ready=%b step0=%h required=0000,1,0180",
               oKey_On, oNote_Ready, oStep0);
    end
    play(1'b1, 7'd64, 16'h0400);
    checks++;
    if (oKey_On !== 4'b0001 || oStep0 !== 16'h0400) begin
      errors++;
      $display("FAIL alloff_free key=%b step0=%h required=0001,0400",
               oKey_On, oStep0);
    end
  endtask

  task automatic test_off_nomatch();
    do_reset();
    play(1'b1, 7'd60, 16'h0100);
    send(1'b0, 7'd99, 16'h0000);
    @(negedge iCLK_18_4);
    checks++;
    if (oNote_Ready !== 1'b0) begin
      errors++;
      $display("FAIL off99_busy ready=%b required=0", oNote_Ready);
    end
    @(negedge iCLK_18_4);
    checks++;
    if (oNote_Ready !== 1'b1 || oKey_On !== 4'b0001 ||
        oStep0 !== 16'h0100 || oDrop !== 1'b0) begin
      errors++;
      $display("FAIL off99 ready=%b key=%b step0=%h drop=%b required=1,0001,0100,0",
               oNote_Ready, oKey_On, oStep0, oDrop);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    play(1'b1, 7'd60, 16'h0100);
    send(1'b1, 7'd60, 16'h0180);
    repeat (6) @(negedge iCLK_18_4);
    #10;
    iRST_N = 1'b0;
    #1;
    checks++;
    if (oKey_On !== 4'b0000 || oNote_Ready !== 1'b1 ||
        oStep0 !== 16'h0000) begin
      errors++;
      $display("FAIL async_rst key=%b ready=%b step0=%h required=0000,1,0000",
               oKey_On, oNote_Ready, oStep0);
    end
    @(negedge iCLK_18_4);
    iRST_N = 1'b1;
    @(negedge iCLK_18_4);
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_reuse();
    test_retrigger();
    test_all_busy();
    test_all_off();
    test_off_nomatch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
